beep_cmd_player: RTL and testbench

- Downstream consumer of the beep command byte FIFO. It pops bytes through a read handshake and parses escape-prefixed commands: 0x1B followed by an opcode and an optional argument.
- It drives the 8-bit pin_out bus: a static LED pattern plus a timed square-wave beep on pin_out[0].
- It sits between the FIFO read side and the board pins, and pairs with the producer that writes sequences like 1B 44 1B.

---
 rtl/beep_pkg.sv | 24 ++
 rtl/beep_tone_gen.sv | 56 +++++
 rtl/beep_cmd_player.sv | 86 ++++++++
 tb/tb_beep_cmd_player.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared opcodes and FSM state encoding for the beep command player.
// The player pops escape-prefixed commands from a byte FIFO and drives LED and tone pins.
package beep_pkg;

    localparam logic [7:0] ESC_DEFAULT = 8'h1B;
    localparam logic [7:0] OP_BEEP     = 8'h44;
    localparam logic [7:0] OP_LED      = 8'h4C;
    localparam logic [7:0] OP_CLR      = 8'h43;

    typedef enum logic [2:0] {
        FETCH_ESC = 3'd0,
        CHK_ESC   = 3'd1,
        FETCH_OP  = 3'd2,
        CHK_OP    = 3'd3,
        FETCH_ARG = 3'd4,
        CHK_ARG   = 3'd5,
        BEEP      = 3'd6
    } state_t;

    function automatic logic is_fetch(input state_t s);
        return (s == FETCH_ESC) || (s == FETCH_OP) || (s == FETCH_ARG);
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Timed square-wave generator: a start pulse runs a beep of exactly BEEP_CYCLES
// cycles, with the tone starting high and toggling every TONE_HALF cycles.
module beep_tone_gen #(
    parameter int TONE_HALF   = 12500,
    parameter int BEEP_CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_tone,
    output logic o_active,
    output logic o_done
);

    localparam int TW = (TONE_HALF   > 1) ? $clog2(TONE_HALF)   : 1;
    localparam int DW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    logic [TW-1:0] r_tone_cnt;
    logic [DW-1:0] r_dur_cnt;
    logic          r_tone;
    logic          r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            r_dur_cnt  <= '0;
            r_tone     <= 1'b0;
            r_active   <= 1'b0;
        end else if (i_start) begin
            r_tone_cnt <= '0;
            r_dur_cnt  <= DW'(BEEP_CYCLES - 1);
            r_tone     <= 1'b1;
            r_active   <= 1'b1;
        end else if (r_active) begin
            // Final beep cycle: park the tone low so the LED bit shows through afterwards.
            if (r_dur_cnt == '0) begin
                r_active   <= 1'b0;
                r_tone     <= 1'b0;
                r_tone_cnt <= '0;
            end else begin
                r_dur_cnt <= r_dur_cnt - 1'b1;
                if (r_tone_cnt == TW'(TONE_HALF - 1)) begin
                    r_tone_cnt <= '0;
                    r_tone     <= ~r_tone;
                end else begin
                    r_tone_cnt <= r_tone_cnt + 1'b1;
                end
            end
        end
    end

    assign o_tone   = r_tone;
    assign o_active = r_active;
    assign o_done   = r_active && (r_dur_cnt == '0);

endmodule

// File: rtl/beep_cmd_player.sv
// Pops bytes from the command FIFO, parses ESC-prefixed commands (beep, set LED,
// clear LED) and drives the LED pins with the beep tone overlaid on bit 0.
module beep_cmd_player
    import beep_pkg::*;
#(
    parameter int         TONE_HALF   = 12500,
    parameter int         BEEP_CYCLES = 1200000,
    parameter logic [7:0] ESC_BYTE    = ESC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       empty_sig,
    input  logic [7:0] fifo_read_data,
    output logic       read_req,
    output logic [7:0] pin_out,
    output logic       busy,
    output logic       cmd_err
);

    state_t     r_state;
    logic [7:0] r_led;
    logic       r_cmd_err;
    logic       w_start;
    logic       w_tone;
    logic       w_active;
    logic       w_done;

    assign w_start = (r_state == CHK_OP) && (fifo_read_data == OP_BEEP);

    beep_tone_gen #(
        .TONE_HALF   (TONE_HALF),
        .BEEP_CYCLES (BEEP_CYCLES)
    ) u_tone (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .o_tone   (w_tone),
        .o_active (w_active),
        .o_done   (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH_ESC;
            r_led     <= 8'h00;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                FETCH_ESC: if (!empty_sig) r_state <= CHK_ESC;
                CHK_ESC:   r_state <= (fifo_read_data == ESC_BYTE) ? FETCH_OP : FETCH_ESC;
                FETCH_OP:  if (!empty_sig) r_state <= CHK_OP;
                CHK_OP: begin
                    if (fifo_read_data == OP_BEEP) begin
                        r_state <= BEEP;
                    end else if (fifo_read_data == OP_LED) begin
                        r_state <= FETCH_ARG;
                    end else if (fifo_read_data == OP_CLR) begin
                        r_led   <= 8'h00;
                        r_state <= FETCH_ESC;
                    end else if (fifo_read_data == ESC_BYTE) begin
                        // Doubled escape: stay aligned and expect the opcode next.
                        r_state <= FETCH_OP;
                    end else begin
                        r_cmd_err <= 1'b1;
                        r_state   <= FETCH_ESC;
                    end
                end
                FETCH_ARG: if (!empty_sig) r_state <= CHK_ARG;
                CHK_ARG: begin
                    r_led   <= fifo_read_data;
                    r_state <= FETCH_ESC;
                end
                BEEP:      if (w_done) r_state <= FETCH_ESC;
                default:   r_state <= FETCH_ESC;
            endcase
        end
    end

    // The pop must be seen by the FIFO in the FETCH cycle so data lands in CHK.
    assign read_req = rst_n && is_fetch(r_state) && !empty_sig;
    assign busy     = (r_state != FETCH_ESC) || w_active;
    assign cmd_err  = r_cmd_err;
    assign pin_out  = (r_state == BEEP) ? {r_led[7:1], w_tone} : r_led;

endmodule

// File: tb/tb_beep_cmd_player.sv
// Bench for beep_cmd_player: directed command table, beep/reset sequences and
// randomized command streams checked against a byte-level reference model.
module tb_beep_cmd_player;

    localparam int         TH  = 4;
    localparam int         BC  = 40;
    localparam logic [7:0] ESC = 8'h1B;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [0:4][7:0] b;
        int              n;
        logic [7:0]      led;
        logic            busy;
        int              errs;
        int              pops;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       empty_sig;
    logic [7:0] fifo_read_data = 8'h00;
    logic       read_req;
    logic [7:0] pin_out;
    logic       busy;
    logic       cmd_err;

    logic [7:0]  mem [4096];
    logic [11:0] wr_ptr = '0;
    logic [11:0] rd_ptr = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_pop = 0;

    int         obs_pops[$];
    logic [7:0] obs_pin[$];
    logic       obs_busy[$];
    int         obs_err;

    int         exp_pops[$];
    int         exp_err;
    int         exp_end;
    logic [7:0] exp_led;
    logic       exp_busy;

    beep_cmd_player #(.TONE_HALF(TH), .BEEP_CYCLES(BC), .ESC_BYTE(ESC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .empty_sig      (empty_sig),
        .fifo_read_data (fifo_read_data),
        .read_req       (read_req),
        .pin_out        (pin_out),
        .busy           (busy),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    // FIFO read side: data appears the cycle after read_req is sampled.
    assign empty_sig = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (read_req && (rd_ptr != wr_ptr)) begin
            fifo_read_data <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_pin_out", pin_out, 8'h00);
        check("rst_read_req", read_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Push a byte stream at a falling edge, then sample outputs once per cycle.
    task automatic run_stream(input bq_t bs, input int ncyc);
        obs_pops.delete();
        obs_pin.delete();
        obs_busy.delete();
        obs_err = 0;
        @(negedge clk);
        foreach (bs[i]) begin
            mem[wr_ptr] = bs[i];
            wr_ptr      = wr_ptr + 1'b1;
        end
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (read_req) obs_pops.push_back(c);
            if (read_req && empty_sig) bad_pop++;
            if (cmd_err) obs_err++;
            obs_pin.push_back(pin_out);
            obs_busy.push_back(busy);
        end
    endtask

    // Byte-level interpretation: every pop costs 2 cycles, a beep adds BC cycles.
    task automatic model(input bq_t bs);
        int t;
        int mode;
        t = 0;
        mode = 0;
        exp_pops.delete();
        exp_err = 0;
        exp_led = 8'h00;
        foreach (bs[i]) begin
            exp_pops.push_back(t);
            t += 2;
            if (mode == 0) begin
                if (bs[i] == ESC) mode = 1;
            end else if (mode == 2) begin
                exp_led = bs[i];
                mode = 0;
            end else begin
                mode = 0;
                if (bs[i] == 8'h44)      t += BC;
                else if (bs[i] == 8'h4C) mode = 2;
                else if (bs[i] == 8'h43) exp_led = 8'h00;
                else if (bs[i] == ESC)   mode = 1;
                else                     exp_err++;
            end
        end
        exp_end  = t;
        exp_busy = (mode != 0);
    endtask

    vec_t tbl[7];

    initial begin
        bq_t        bs;
        int         bad;
        logic [7:0] led_a5;
        logic       tn;

        tbl[0] = '{b:{8'h1B, 8'h4C, 8'hA5, 8'h00, 8'h00}, n:3, led:8'hA5, busy:1'b0, errs:0, pops:3};
        tbl[1] = '{b:{8'h55, 8'h1B, 8'h1B, 8'h7E, 8'h00}, n:4, led:8'h00, busy:1'b0, errs:1, pops:4};
        tbl[2] = '{b:{8'h1B, 8'h4C, 8'h1B, 8'h00, 8'h00}, n:3, led:8'h1B, busy:1'b0, errs:0, pops:3};
        tbl[3] = '{b:{8'h1B, 8'h4C, 8'h3C, 8'h1B, 8'h43}, n:5, led:8'h00, busy:1'b0, errs:0, pops:5};
        tbl[4] = '{b:{8'h1B, 8'h00, 8'h00, 8'h00, 8'h00}, n:1, led:8'h00, busy:1'b1, errs:0, pops:1};
        tbl[5] = '{b:{8'h1B, 8'h4C, 8'h00, 8'h00, 8'h00}, n:2, led:8'h00, busy:1'b1, errs:0, pops:2};
        tbl[6] = '{b:{8'h1B, 8'h4C, 8'hFF, 8'h1B, 8'h99}, n:5, led:8'hFF, busy:1'b0, errs:1, pops:5};

        do_reset();
        bs = {};
        run_stream(bs, 6);
        check("idle_pops", obs_pops.size(), 0);
        check("idle_pin_out", obs_pin[$], 8'h00);
        check("idle_busy", obs_busy[$], 1'b0);

        for (int k = 0; k < 7; k++) begin
            do_reset();
            bs = {};
            for (int i = 0; i < tbl[k].n; i++) bs.push_back(tbl[k].b[i]);
            run_stream(bs, 2 * tbl[k].n + 8);
            check($sformatf("tbl%0d_pin_out", k), obs_pin[$], tbl[k].led);
            check($sformatf("tbl%0d_busy", k), obs_busy[$], tbl[k].busy);
            check($sformatf("tbl%0d_cmd_err", k), obs_err, tbl[k].errs);
            check($sformatf("tbl%0d_pops", k), obs_pops.size(), tbl[k].pops);
            bad = 0;
            foreach (obs_pops[i]) if (obs_pops[i] != 2 * i) bad++;
            check($sformatf("tbl%0d_pop_timing", k), bad, 0);
        end

        // Beep with led=A5: tone on bit 0 for exactly BC cycles starting high.
        do_reset();
        run_stream('{8'h1B, 8'h4C, 8'hA5}, 10);
        run_stream('{8'h1B, 8'h44}, 50);
        led_a5 = 8'hA5;
        bad = 0;
        for (int c = 4; c < 4 + BC; c++) begin
            tn = (((c - 4) / TH) % 2) == 0;
            if (obs_pin[c] !== {led_a5[7:1], tn}) bad++;
            if (obs_busy[c] !== 1'b1) bad++;
        end
        check("beep_wave", bad, 0);
        check("beep_pops", obs_pops.size(), 2);
        check("beep_last_busy", obs_busy[3 + BC], 1'b1);
        check("beep_end_pin_out", obs_pin[4 + BC], 8'hA5);
        check("beep_end_busy", obs_busy[4 + BC], 1'b0);

        // Trailing lone ESC after a beep, then a clear completes it.
        run_stream('{8'h1B, 8'h44, 8'h1B}, 60);
        check("tail_pops", obs_pops.size(), 3);
        check("tail_pop_after_beep", obs_pops[$], 4 + BC);
        check("tail_busy", obs_busy[$], 1'b1);
        check("tail_pin_out", obs_pin[$], 8'hA5);
        run_stream('{8'h43}, 8);
        check("clr_pop_time", obs_pops[0], 0);
        check("clr_pin_out", obs_pin[2], 8'h00);
        check("clr_busy", obs_busy[$], 1'b0);

        // Asynchronous reset ten cycles into a beep.
        do_reset();
        run_stream('{8'h1B, 8'h4C, 8'hF0, 8'h1B, 8'h44}, 20);
        check("prerst_pin_out", obs_pin[19], 8'hF1);
        rst_n = 1'b0;
        #1;
        check("midbeep_rst_pin_out", pin_out, 8'h00);
        check("midbeep_rst_read_req", read_req, 1'b0);
        check("midbeep_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_stream('{8'h1B, 8'h4C, 8'h0F}, 12);
        check("postrst_pin_out", obs_pin[$], 8'h0F);
        check("postrst_pops", obs_pops.size(), 3);

        // Randomized command streams against the reference model.
        for (int r = 0; r < 25; r++) begin
            int         n;
            int         sel;
            logic [7:0] rb;
            do_reset();
            bs = {};
            n = $urandom_range(3, 14);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 9);
                rb  = 8'($urandom_range(0, 255));
                if (sel < 3)       rb = ESC;
                else if (sel == 3) rb = 8'h44;
                else if (sel == 4) rb = 8'h4C;
                else if (sel == 5) rb = 8'h43;
                bs.push_back(rb);
            end
            model(bs);
            run_stream(bs, exp_end + 6);
            check($sformatf("rnd%0d_pops", r), obs_pops.size(), exp_pops.size());
            bad = 0;
            foreach (exp_pops[i]) if (i >= obs_pops.size() || obs_pops[i] != exp_pops[i]) bad++;
            check($sformatf("rnd%0d_pop_timing", r), bad, 0);
            check($sformatf("rnd%0d_cmd_err", r), obs_err, exp_err);
            check($sformatf("rnd%0d_pin_out", r), obs_pin[$], exp_led);
            check($sformatf("rnd%0d_busy", r), obs_busy[$], exp_busy);
        end

        check("no_pop_when_empty", bad_pop, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
